cordic_issuer: RTL and testbench

- Command-side driver and result collector for the 16-bit CORDIC datapath.
- Accepts operations on a valid/ready command stream and drives the CORDIC `start/mode/shift/opa/opb` inputs.
- Tracks in-flight operations through the 6-stage CORDIC pipeline and captures `data_o` into a response FIFO with the command's tag and mode.
- Keeps CORDIC `start` asserted continuously while any operation is in flight, because both the CORDIC stages and the reciprocal chain need an unbroken `start` to stay aligned.

---
 rtl/cordic_issuer.sv | 181 ++++++++++++++++++
 tb/tb_cordic_issuer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_issuer.sv
`timescale 1ns/1ps
// cordic_issuer: issues commands into the 6-stage CORDIC pipeline, tracks the
// in-flight operations and collects the results into a FWFT response FIFO.
// Issue credit (FIFO entries plus in-flight ops) means a capture never finds
// the FIFO full.
module cordic_issuer #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 4,
  parameter int RSP_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_mode,
  input  logic [3:0]              cmd_shift,
  input  logic [2*DATA_WIDTH-1:0] cmd_opa,
  input  logic [2*DATA_WIDTH-1:0] cmd_opb,
  input  logic [TAG_WIDTH-1:0]    cmd_tag,
  output logic                    cdc_start,
  output logic [2:0]              cdc_mode,
  output logic [3:0]              cdc_shift,
  output logic [2*DATA_WIDTH-1:0] cdc_opa,
  output logic [2*DATA_WIDTH-1:0] cdc_opb,
  input  logic [2*DATA_WIDTH-1:0] cdc_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic [2:0]              rsp_mode,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  output logic                    busy
);

  localparam int OW   = 2 * DATA_WIDTH;
  localparam int NSTG = 6;
  localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW   = $clog2(RSP_DEPTH + 1);
  localparam int OCW  = $clog2(RSP_DEPTH + NSTG + 1) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_reg, state_next;
  logic [NSTG-1:0]        vld_pipe_reg, vld_pipe_next;
  logic                   ready_reg;
  logic                   accept;
  logic                   push, pop;
  logic [TAG_WIDTH-1:0]   tag_in;
  logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]          count_reg, count_next;
  logic [OCW-1:0]         occ_next;

  logic [OW-1:0]          fifo_data_mem [RSP_DEPTH];
  logic [2:0]             fifo_mode_mem [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]   fifo_tag_mem  [RSP_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cmd_ready = ready_reg;
  assign accept    = cmd_valid && ready_reg;
  assign push      = vld_pipe_reg[NSTG-1];
  assign rsp_valid = (count_reg != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign tag_in    = accept ? cmd_tag : '0;
  assign busy      = (state_reg == RUN) || rsp_valid;

  // Next-state and CORDIC drive: start stays high while anything is in flight,
  // bubbles carry all-zero fields.
  always_comb begin
    state_next = state_reg;
    cdc_start  = accept || (|vld_pipe_reg[NSTG-2:0]);
    cdc_mode   = '0;
    cdc_shift  = '0;
    cdc_opa    = '0;
    cdc_opb    = '0;
    if (accept) begin
      cdc_mode  = cmd_mode;
      cdc_shift = cmd_shift;
      cdc_opa   = cmd_opa;
      cdc_opb   = cmd_opb;
    end
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (!cdc_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Valid pipe advances only with start; a final capture with start low
  // retires stage 5 explicitly.
  always_comb begin
    vld_pipe_next = vld_pipe_reg;
    if (cdc_start) begin
      vld_pipe_next = {vld_pipe_reg[NSTG-2:0], accept};
    end else begin
      vld_pipe_next[NSTG-1] = 1'b0;
    end
  end

  // FIFO occupancy after this cycle plus in-flight ops gives next-cycle credit.
  always_comb begin
    count_next = count_reg + CW'(push) - CW'(pop);
    occ_next   = OCW'(count_next);
    for (int i = 0; i < NSTG; i++) begin
      occ_next = occ_next + OCW'(vld_pipe_next[i]);
    end
  end

  // Control registers: FSM state, valid pipe, issue credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      vld_pipe_reg <= '0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      vld_pipe_reg <= vld_pipe_next;
      ready_reg    <= (occ_next < OCW'(RSP_DEPTH));
    end
  end

  // Tag/mode pipe, one stage per generate block, shifting in lockstep with vld.
  genvar gi;
  generate
    for (gi = 0; gi < NSTG; gi++) begin : g_meta
      logic [TAG_WIDTH-1:0] tag_q;
      logic [2:0]           mode_q;
      if (gi == 0) begin : g_head
        // First stage loads the issued command's tag and mode.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            tag_q  <= '0;
            mode_q <= '0;
          end else if (cdc_start) begin
            tag_q  <= tag_in;
            mode_q <= cdc_mode;
          end
        end
      end else begin : g_tail
        // Later stages copy the previous stage.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            tag_q  <= '0;
            mode_q <= '0;
          end else if (cdc_start) begin
            tag_q  <= g_meta[gi-1].tag_q;
            mode_q <= g_meta[gi-1].mode_q;
          end
        end
      end
    end
  endgenerate

  // Response storage write on capture.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_reg] <= cdc_data;
      fifo_mode_mem[wr_ptr_reg] <= g_meta[NSTG-1].mode_q;
      fifo_tag_mem[wr_ptr_reg]  <= g_meta[NSTG-1].tag_q;
    end
  end

  // FIFO pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_next;
    end
  end

  assign rsp_data = fifo_data_mem[rd_ptr_reg];
  assign rsp_mode = fifo_mode_mem[rd_ptr_reg];
  assign rsp_tag  = fifo_tag_mem[rd_ptr_reg];

endmodule

// File: tb/tb_cordic_issuer.sv
`timescale 1ns/1ps
// Bench for cordic_issuer: stand-in CORDIC datapath, cycle-level reference
// model built on accept times, table vectors and hand-written corner sequences.
module tb_cordic_issuer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_mode;
  logic [3:0]  cmd_shift;
  logic [31:0] cmd_opa, cmd_opb;
  logic [3:0]  cmd_tag;
  logic        cdc_start;
  logic [2:0]  cdc_mode;
  logic [3:0]  cdc_shift;
  logic [31:0] cdc_opa, cdc_opb, cdc_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_mode;
  logic [3:0]  rsp_tag;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_issuer #(.DATA_WIDTH(16), .TAG_WIDTH(4), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_shift(cmd_shift), .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_tag(cmd_tag),
    .cdc_start(cdc_start), .cdc_mode(cdc_mode), .cdc_shift(cdc_shift),
    .cdc_opa(cdc_opa), .cdc_opb(cdc_opb), .cdc_data(cdc_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_mode(rsp_mode), .rsp_tag(rsp_tag), .busy(busy)
  );

  // Stand-in datapath: rotate/phase = opa^opb, magnitude = isqrt(re^2+im^2),
  // mag+phase adds imag=1, reciprocal bit xors in the shift field.
  function automatic logic [31:0] cordic_fn(input logic [2:0] m, input logic [3:0] sh,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    longint re, im, s, q, c;
    re = longint'($signed(a[31:16]));
    im = longint'($signed(a[15:0]));
    if (m[1:0] < 2'd2) begin
      r = a ^ b;
    end else begin
      s = re * re + im * im;
      q = 0;
      for (int bt = 15; bt >= 0; bt--) begin
        c = q | (longint'(1) << bt);
        if (c * c <= s) q = c;
      end
      r = {16'(q), (m[1:0] == 2'd3) ? 16'h0001 : 16'h0000};
    end
    if (m[2]) r = r ^ {28'h0, sh};
    return r;
  endfunction

  // Six-deep datapath that advances only while start is high.
  logic [31:0] cpipe [6];
  initial for (int i = 0; i < 6; i++) cpipe[i] = '0;
  always @(posedge clk) begin
    if (cdc_start) begin
      cpipe[0] <= cordic_fn(cdc_mode, cdc_shift, cdc_opa, cdc_opb);
      for (int i = 1; i < 6; i++) cpipe[i] <= cpipe[i-1];
    end
  end
  assign cdc_data = cpipe[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_near(input string nm, input logic [31:0] act, input logic [31:0] exp);
    int dr, di;
    dr = int'($signed(act[31:16])) - int'($signed(exp[31:16]));
    di = int'($signed(act[15:0])) - int'($signed(exp[15:0]));
    n_vec++;
    if (dr > 4 || dr < -4 || di > 4 || di < -4) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (+-4 per half)", nm, act, exp);
    end
  endtask

  // Reference model: an op accepted in cycle t keeps start high t..t+5, is
  // captured at the end of t+6; credit = queued results + ops accepted in the
  // previous six cycles.
  typedef struct { logic [2:0] mode; logic [3:0] shift; logic [31:0] opa, opb; logic [3:0] tag; int t; } op_t;
  typedef struct { logic [31:0] data; logic [2:0] mode; logic [3:0] tag; } rsp_t;
  op_t  inflight[$];
  rsp_t fifo_q[$];
  int   mt = 0;

  // Every cycle: compare all outputs against the model, then advance it.
  always @(negedge clk) begin : monitor
    bit   exp_ready, acc, exp_start, exp_rv;
    op_t  o;
    rsp_t r;
    if (!rst_n) begin
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_outputs", {cdc_start, cdc_mode, cdc_shift, cdc_opa, cdc_opb, rsp_valid, busy}, '0);
      inflight.delete();
      fifo_q.delete();
      mt = 0;
    end else begin
      exp_ready = (fifo_q.size() + inflight.size()) < DEPTH;
      chk("m_cmd_ready", cmd_ready, exp_ready);
      acc = cmd_valid && exp_ready;
      exp_start = acc || (inflight.size() > 0 && inflight[$].t >= mt - 5);
      chk("m_cdc_start", cdc_start, exp_start);
      chk("m_cdc_fields", {cdc_mode, cdc_shift, cdc_opa, cdc_opb},
          acc ? {cmd_mode, cmd_shift, cmd_opa, cmd_opb} : 71'h0);
      exp_rv = fifo_q.size() > 0;
      chk("m_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv && rsp_valid)
        chk("m_rsp_payload", {rsp_data, rsp_mode, rsp_tag},
            {fifo_q[0].data, fifo_q[0].mode, fifo_q[0].tag});
      chk("m_busy", busy, (inflight.size() > 0) || exp_rv);
      if (exp_rv && rsp_ready) void'(fifo_q.pop_front());
      if (inflight.size() > 0 && inflight[0].t == mt - 6) begin
        o = inflight.pop_front();
        r.data = cordic_fn(o.mode, o.shift, o.opa, o.opb);
        r.mode = o.mode;
        r.tag  = o.tag;
        fifo_q.push_back(r);
      end
      if (acc) begin
        o.mode = cmd_mode; o.shift = cmd_shift; o.opa = cmd_opa; o.opb = cmd_opb;
        o.tag = cmd_tag; o.t = mt;
        inflight.push_back(o);
      end
      mt++;
    end
  end

  typedef struct { logic [2:0] mode; logic [3:0] shift; logic [31:0] opa, opb; logic [3:0] tag; logic [31:0] exp_data; } vec_t;
  vec_t tbl [5];

  task automatic step_in();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step_in();
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
  endtask

  // One command; checks start span, 7-cycle latency and the returned fields.
  task automatic send1(input vec_t v);
    int lat, starts;
    bit got;
    step_in();
    cmd_valid = 1'b1; cmd_mode = v.mode; cmd_shift = v.shift;
    cmd_opa = v.opa; cmd_opb = v.opb; cmd_tag = v.tag; rsp_ready = 1'b1;
    @(negedge clk);
    chk("send_accept", cmd_ready, 1'b1);
    step_in();
    cmd_valid = 1'b0;
    lat = 0; starts = 0; got = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1; lat = k;
        chk("send_tag", rsp_tag, v.tag);
        chk("send_mode", rsp_mode, v.mode);
        chk_near("send_data", rsp_data, v.exp_data);
      end else if (cdc_start) begin
        starts++;
      end
    end
    chk("send_latency", lat, 7);
    chk("send_start_cycles", starts, 5);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nt, nacc;
    int got[$];
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_shift = '0;
    cmd_opa = '0; cmd_opb = '0; cmd_tag = '0; rsp_ready = 1'b0;

    tbl[0] = '{3'd0, 4'h0, 32'h4000_0000, 32'h0000_0000, 4'd3,  32'h4000_0000};
    tbl[1] = '{3'd2, 4'h0, 32'h3000_4000, 32'h0000_0000, 4'd1,  32'h5000_0000};
    tbl[2] = '{3'd1, 4'h0, 32'h1234_5678, 32'h0F0F_0F0F, 4'd9,  32'h1D3B_5977};
    tbl[3] = '{3'd5, 4'hA, 32'h0001_0000, 32'h0000_0000, 4'd15, 32'h0001_000A};
    tbl[4] = '{3'd3, 4'h0, 32'h0600_0800, 32'h0000_0000, 4'd0,  32'h0A00_0001};

    #3;
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    chk("post_reset_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 5; i++) begin
      send1(tbl[i]);
      idle(3);
    end

    // Burst into a stalled FIFO: exactly DEPTH accepted, then ordered drain.
    nt = 0; nacc = 0; got.delete();
    for (int k = 0; k < 60; k++) begin
      step_in();
      cmd_valid = (nt < 10); cmd_tag = 4'(nt); cmd_mode = 3'd0;
      cmd_opa = {16'(nt), 16'h0}; cmd_opb = 32'h0;
      rsp_ready = (k >= 20);
      @(negedge clk);
      if (k == 8) chk("burst_ready_9th", cmd_ready, 1'b0);
      if (cmd_valid && cmd_ready) begin nt++; nacc++; end
      if (k == 19) chk("burst_accepted", nacc, 8);
      if (rsp_valid && rsp_ready) got.push_back(int'(rsp_tag));
    end
    chk("burst_rsp_count", got.size(), 10);
    for (int i = 0; i < got.size(); i++) chk("burst_order", got[i], i);
    idle(3);

    // Bubble: commands two cycles apart, start held, one bubble in between.
    for (int k = 0; k < 12; k++) begin
      step_in();
      cmd_valid = (k == 0 || k == 2); cmd_tag = 4'(k + 5); cmd_mode = 3'd2;
      cmd_opa = 32'h7777_1234; cmd_opb = 32'h5555_AAAA; cmd_shift = 4'h6;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bubble_start", cdc_start, (k <= 7));
      chk("bubble_rsp_valid", rsp_valid, (k == 7 || k == 9));
      if (k == 1) chk("bubble_fields", {cdc_mode, cdc_shift, cdc_opa, cdc_opb}, '0);
    end
    idle(3);

    // Reset with three ops in flight.
    for (int k = 0; k < 3; k++) begin
      step_in();
      cmd_valid = 1'b1; cmd_tag = 4'(k); cmd_opa = 32'h0100_0200;
    end
    step_in();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {cdc_start, rsp_valid, busy, cmd_ready}, 4'b0000);
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step_in();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 1'b0);
    end
    send1(tbl[0]);
    idle(3);

    // FIFO at DEPTH-1 with a capture and a pop in the same cycle.
    nt = 0; got.delete();
    for (int k = 0; k < 40; k++) begin
      step_in();
      cmd_valid = (nt < 8); cmd_tag = 4'(nt); cmd_mode = 3'd1;
      cmd_opa = {16'h0, 16'(nt * 3)}; cmd_opb = 32'h0;
      rsp_ready = (k == 13) || (k >= 20);
      @(negedge clk);
      if (k == 13) chk("full_ready_k13", cmd_ready, 1'b0);
      if (k == 14) chk("full_ready_k14", cmd_ready, 1'b1);
      if (cmd_valid && cmd_ready) nt++;
      if (rsp_valid && rsp_ready) got.push_back(int'(rsp_tag));
    end
    chk("full_rsp_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) chk("full_order", got[i], i);
    idle(3);

    // Random traffic against the reference model.
    for (int k = 0; k < 800; k++) begin
      step_in();
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_mode  = 3'($urandom_range(0, 7));
      cmd_shift = 4'($urandom);
      cmd_opa   = $urandom;
      cmd_opb   = $urandom;
      cmd_tag   = 4'($urandom);
      rsp_ready = (k < 400) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
    end
    idle(20);
    @(negedge clk);
    chk("end_busy", busy, 1'b0);
    chk("end_rsp_valid", rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
